// File: rtl/twos_complement_seq.sv
// Multi-cycle two's-complement unit (PASS/NEG/ABS/NABS), CHUNK bits per cycle, LSB first.
// Define SAT_EN to saturate overflowing results to MAX instead of wrapping to MIN.
module twos_complement_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX = ~MIN;

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
            $error("twos_complement_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  x_reg, x_next;
    logic [WIDTH-1:0]  res_reg, res_next;
    logic              carry_reg, carry_next;
    logic              inv_reg, inv_next;
    logic              ovf_pend_reg, ovf_pend_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  data_reg, data_next;
    logic              ovf_reg, ovf_next;
    logic              zero_reg, zero_next;

    logic              inv_sel;
    logic [CHUNK-1:0]  x_chunk;
    logic [CHUNK-1:0]  x_cond;
    logic [CHUNK:0]    sum;
    logic [WIDTH-1:0]  res_ins;
    logic [WIDTH-1:0]  final_val;

    // Conditional inversion of the current chunk, one XOR per bit.
    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_inv
            assign x_cond[gi] = x_chunk[gi] ^ inv_reg;
        end
    endgenerate

    always_comb begin
        inv_sel = 1'b0;
        case (mode)
            2'b00: inv_sel = 1'b0;
            2'b01: inv_sel = 1'b1;
            2'b10: inv_sel = in_data[WIDTH-1];
            2'b11: inv_sel = ~in_data[WIDTH-1] && (|in_data);
            default: inv_sel = 1'b0;
        endcase
    end

    always_comb begin
        x_chunk = x_reg[cnt_reg*CHUNK +: CHUNK];
        sum     = {1'b0, x_cond} + {{CHUNK{1'b0}}, carry_reg};
        res_ins = res_reg;
        res_ins[cnt_reg*CHUNK +: CHUNK] = sum[CHUNK-1:0];
`ifdef SAT_EN
        final_val = ovf_pend_reg ? MAX : res_ins;
`else
        final_val = res_ins;
`endif
    end

    always_comb begin
        state_next    = state_reg;
        x_next        = x_reg;
        res_next      = res_reg;
        carry_next    = carry_reg;
        inv_next      = inv_reg;
        ovf_pend_next = ovf_pend_reg;
        cnt_next      = cnt_reg;
        data_next     = data_reg;
        ovf_next      = ovf_reg;
        zero_next     = zero_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next    = BUSY;
                    x_next        = in_data;
                    res_next      = '0;
                    inv_next      = inv_sel;
                    carry_next    = inv_sel;
                    ovf_pend_next = inv_sel && (in_data == MIN);
                    cnt_next      = '0;
                end
            end
            BUSY: begin
                res_next   = res_ins;
                carry_next = sum[CHUNK];
                if (cnt_reg == CW'(NCHUNK - 1)) begin
                    // Result registers update only here, so they hold through DONE and IDLE.
                    state_next = DONE;
                    data_next  = final_val;
                    ovf_next   = ovf_pend_reg;
                    zero_next  = (final_val == '0);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            res_reg      <= '0;
            carry_reg    <= 1'b0;
            inv_reg      <= 1'b0;
            ovf_pend_reg <= 1'b0;
            cnt_reg      <= '0;
            data_reg     <= '0;
            ovf_reg      <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            res_reg      <= res_next;
            carry_reg    <= carry_next;
            inv_reg      <= inv_next;
            ovf_pend_reg <= ovf_pend_next;
            cnt_reg      <= cnt_next;
            data_reg     <= data_next;
            ovf_reg      <= ovf_next;
            zero_reg     <= zero_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = data_reg;
    assign out_ovf   = ovf_reg;
    assign out_zero  = zero_reg;

endmodule

// File: tb/tb_twos_complement_seq.sv
// Scoreboard bench for twos_complement_seq (WIDTH=8, CHUNK=2): directed vectors, decoupled monitor.
module tb_twos_complement_seq;

    localparam int NCHUNK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       out_zero;

    typedef struct {
        logic [7:0] d;
        logic       o;
        logic       z;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic       prev_valid = 1'b0;
    logic [7:0] held_d;
    logic       held_o;
    logic       held_z;

`ifdef SAT_EN
    localparam logic [7:0] MIN_NEG = 8'h7F;
`else
    localparam logic [7:0] MIN_NEG = 8'h80;
`endif

    twos_complement_seq #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks each result against the scoreboard and its hold stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_ovf",  32'(out_ovf),  32'(e.o));
                    chk("out_zero", 32'(out_zero), 32'(e.z));
                    chk("latency",  32'(cyc - e.acc), 32'(NCHUNK));
                    $display("result d=%02h ovf=%0b zero=%0b at cycle %0d", out_data, out_ovf, out_zero, cyc);
                end
                held_d <= out_data;
                held_o <= out_ovf;
                held_z <= out_zero;
            end else if (out_valid && prev_valid) begin
                chk("hold_data", 32'(out_data), 32'(held_d));
                chk("hold_flags", 32'({out_ovf, out_zero}), 32'({held_o, held_z}));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            prev_valid <= out_valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic push,
                        input logic [7:0] ed, input logic eo, input logic ez);
        exp_t e;
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        if (push) begin
            e.d = ed; e.o = eo; e.z = ez; e.acc = cyc + 1;
            q.push_back(e);
        end
        $display("issue d=%02h mode=%0d at cycle %0d", d, m, cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h5A;
        mode     = 2'b01;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; mode = 2'b00; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", 32'({out_data, out_ovf, out_zero}), 32'd0);
        rst = 1'b0;

        send(8'h01, 2'b01, 1'b1, 8'hFF, 1'b0, 1'b0);
        send(8'h80, 2'b01, 1'b1, MIN_NEG, 1'b1, 1'b0);
        send(8'h80, 2'b11, 1'b1, 8'h80, 1'b0, 1'b0);
        send(8'hFF, 2'b10, 1'b1, 8'h01, 1'b0, 1'b0);
        send(8'h05, 2'b10, 1'b1, 8'h05, 1'b0, 1'b0);
        send(8'h05, 2'b11, 1'b1, 8'hFB, 1'b0, 1'b0);
        send(8'h9C, 2'b00, 1'b1, 8'h9C, 1'b0, 1'b0);
        send(8'h00, 2'b01, 1'b1, 8'h00, 1'b0, 1'b1);
        send(8'h00, 2'b11, 1'b1, 8'h00, 1'b0, 1'b1);
        send(8'h7F, 2'b01, 1'b1, 8'h81, 1'b0, 1'b0);
        drain();

        // Backpressure: hold result 3 clocks, pulse in_valid while in DONE.
        out_ready = 1'b0;
        send(8'h40, 2'b01, 1'b1, 8'hC0, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h11; mode = 2'b01;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", 32'({in_ready, out_valid}), 32'b10);
        repeat (8) @(negedge clk);
        drain();

        // Reset two clocks into BUSY abandons the operand.
        send(8'h33, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_outs", 32'({out_data, out_ovf, out_zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        send(8'h02, 2'b01, 1'b1, 8'hFE, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

endmodule
